// File: rtl/d5m_pkg.sv
// d5m_pkg: shared types and helpers for the TRDB-D5M sensor stream generator.
//   pattern_e : test-pattern selector encoding (matches the 2-bit pattern port)
//   state_e   : frame-timing FSM states
//   D5M_DATA_W: default pixel width of the sensor data bus
//   cnt_w()   : width needed to hold counts 0..max-1 of the largest argument
package d5m_pkg;

  localparam int D5M_DATA_W = 12;

  typedef enum logic [1:0] {
    PAT_HRAMP   = 2'd0,
    PAT_VRAMP   = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_COUNT   = 2'd3
  } pattern_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VBLANK = 3'd1,
    ST_LEAD   = 3'd2,
    ST_LINE   = 3'd3,
    ST_HBLANK = 3'd4,
    ST_TRAIL  = 3'd5
  } state_e;

  // Bits needed to count 0..max(a,b,c,d)-1; never less than 1.
  function automatic int cnt_w(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/d5m_pattern_gen.sv
// d5m_pattern_gen: combinational test-pattern source for the D5M stream generator.
// Ports:
//   x, y         in   current pixel column / line inside the active window
//   frame_count  in   completed-frame counter (offset for the running-count pattern)
//   pattern      in   latched pattern select (pattern_e encoding)
//   pixel        out  DATA_W-bit pixel value, truncated to DATA_W
module d5m_pattern_gen
  import d5m_pkg::*;
#(
  parameter int DATA_W = D5M_DATA_W,
  parameter int WIDTH  = 640,
  parameter int X_W    = 10,
  parameter int Y_W    = 9
) (
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic [15:0]       frame_count,
  input  logic [1:0]        pattern,
  output logic [DATA_W-1:0] pixel
);

  logic [31:0] lin_idx;

  always_comb begin
    // Linear pixel index offset by frame number; wraps naturally on truncation.
    lin_idx = 32'(frame_count) + 32'(y) * 32'(WIDTH) + 32'(x);
    pixel   = '0;
    case (pattern_e'(pattern))
      PAT_HRAMP:   pixel = DATA_W'(x);
      PAT_VRAMP:   pixel = DATA_W'(y);
      PAT_CHECKER: pixel = (x[0] ^ y[0]) ? '0 : '1;
      PAT_COUNT:   pixel = DATA_W'(lin_idx);
      default:     pixel = '0;
    endcase
  end

endmodule

// File: rtl/d5m_sensor_stream_gen.sv
// d5m_sensor_stream_gen: transmit side of the TRDB-D5M pixel interface. Produces
// FRAME_VALID / LINE_VALID / DATA with sensor timing, carrying synthetic patterns.
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high; aborts any frame in progress
//   pix_ce       in   pixel tick; timing and sensor outputs advance only when high
//   enable       in   level; starts frames and keeps streaming while high
//   pattern      in   0 h-ramp, 1 v-ramp, 2 checker, 3 running count (sampled per frame)
//   frame_valid  out  sensor FRAME_VALID
//   line_valid   out  sensor LINE_VALID
//   data         out  sensor DATA (0 whenever line_valid is low)
//   frame_done   out  one-clock pulse at the end of every frame
//   frame_count  out  completed frames, wraps at 16 bits
//   busy         out  high whenever the FSM is not idle
module d5m_sensor_stream_gen
  import d5m_pkg::*;
#(
  parameter int DATA_W   = D5M_DATA_W,
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int HBLANK   = 16,
  parameter int VBLANK   = 32,
  parameter int FV_LEAD  = 4,
  parameter int FV_TRAIL = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_ce,
  input  logic              enable,
  input  logic [1:0]        pattern,
  output logic              frame_valid,
  output logic              line_valid,
  output logic [DATA_W-1:0] data,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              busy
);

  localparam int X_W    = $clog2(WIDTH);
  localparam int Y_W    = $clog2(HEIGHT);
  localparam int TICK_W = cnt_w(VBLANK, HBLANK, FV_LEAD, FV_TRAIL);

  localparam logic [X_W-1:0]    X_LAST    = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(HEIGHT - 1);
  localparam logic [TICK_W-1:0] VBL_LOAD  = TICK_W'(VBLANK - 1);
  localparam logic [TICK_W-1:0] HBL_LOAD  = TICK_W'(HBLANK - 1);
  localparam logic [TICK_W-1:0] LEAD_LOAD = TICK_W'(FV_LEAD - 1);
  localparam logic [TICK_W-1:0] TRL_LOAD  = TICK_W'(FV_TRAIL - 1);

  state_e            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [1:0]        pat_q, pat_d;

  logic              emit_fv, emit_lv, frame_end;
  logic [DATA_W-1:0] pixel;

  logic              fv_p1, lv_p1, done_p1;
  logic [DATA_W-1:0] data_p1;
  logic [15:0]       frame_cnt_q;

  d5m_pattern_gen #(
    .DATA_W (DATA_W),
    .WIDTH  (WIDTH),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) u_pattern_gen (
    .x           (x_q),
    .y           (y_q),
    .frame_count (frame_cnt_q),
    .pattern     (pat_q),
    .pixel       (pixel)
  );

  // The current state describes the sample emitted on this tick; the state
  // register then moves to whatever the next tick must emit.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    x_d       = x_q;
    y_d       = y_q;
    pat_d     = pat_q;
    emit_fv   = 1'b0;
    emit_lv   = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_VBLANK;
          tick_d  = VBL_LOAD;
          pat_d   = pattern;
        end
      end
      ST_VBLANK: begin
        if (tick_q == '0) begin
          state_d = ST_LEAD;
          tick_d  = LEAD_LOAD;
        end else begin
          tick_d = tick_q - TICK_W'(1);
        end
      end
      ST_LEAD: begin
        emit_fv = 1'b1;
        if (tick_q == '0) begin
          state_d = ST_LINE;
          x_d     = '0;
          y_d     = '0;
        end else begin
          tick_d = tick_q - TICK_W'(1);
        end
      end
      ST_LINE: begin
        emit_fv = 1'b1;
        emit_lv = 1'b1;
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            state_d = ST_TRAIL;
            tick_d  = TRL_LOAD;
          end else begin
            state_d = ST_HBLANK;
            tick_d  = HBL_LOAD;
          end
        end else begin
          x_d = x_q + X_W'(1);
        end
      end
      ST_HBLANK: begin
        emit_fv = 1'b1;
        if (tick_q == '0) begin
          state_d = ST_LINE;
          x_d     = '0;
          y_d     = y_q + Y_W'(1);
        end else begin
          tick_d = tick_q - TICK_W'(1);
        end
      end
      ST_TRAIL: begin
        emit_fv = 1'b1;
        if (tick_q == '0) begin
          frame_end = 1'b1;
          // enable is only consulted here, so a frame is never cut short.
          if (enable) begin
            state_d = ST_VBLANK;
            tick_d  = VBL_LOAD;
            pat_d   = pattern;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tick_d = tick_q - TICK_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output stage p1: registered sensor pins, frozen between pixel ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      pat_q       <= '0;
      fv_p1       <= 1'b0;
      lv_p1       <= 1'b0;
      data_p1     <= '0;
      done_p1     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      done_p1 <= 1'b0;
      if (pix_ce) begin
        state_q <= state_d;
        tick_q  <= tick_d;
        x_q     <= x_d;
        y_q     <= y_d;
        pat_q   <= pat_d;
        fv_p1   <= emit_fv;
        lv_p1   <= emit_lv;
        data_p1 <= emit_lv ? pixel : '0;
        if (frame_end) begin
          done_p1     <= 1'b1;
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end
      end
    end
  end

  assign frame_valid = fv_p1;
  assign line_valid  = lv_p1;
  assign data        = data_p1;
  assign frame_done  = done_p1;
  assign frame_count = frame_cnt_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_d5m_sensor_stream_gen.sv
// Testbench for d5m_sensor_stream_gen with small timing parameters.
// Expected per-tick samples are queued by the stimulus; a monitor compares them.
module tb_d5m_sensor_stream_gen;

  localparam int DATA_W   = 12;
  localparam int WIDTH    = 4;
  localparam int HEIGHT   = 3;
  localparam int HBLANK   = 2;
  localparam int VBLANK   = 3;
  localparam int FV_LEAD  = 1;
  localparam int FV_TRAIL = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              pix_ce = 1'b0;
  logic              enable = 1'b0;
  logic [1:0]        pattern = 2'd0;
  logic              frame_valid, line_valid, frame_done, busy;
  logic [DATA_W-1:0] data;
  logic [15:0]       frame_count;

  d5m_sensor_stream_gen #(
    .DATA_W   (DATA_W),
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .HBLANK   (HBLANK),
    .VBLANK   (VBLANK),
    .FV_LEAD  (FV_LEAD),
    .FV_TRAIL (FV_TRAIL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_ce      (pix_ce),
    .enable      (enable),
    .pattern     (pattern),
    .frame_valid (frame_valid),
    .line_valid  (line_valid),
    .data        (data),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fv;
    logic        lv;
    logic [11:0] data;
    logic        fd;
    logic [15:0] fc;
  } tick_t;

  tick_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Pixel-tick generator: high one clock in every ce_div clocks.
  int   ce_div = 1;
  int   ce_cnt = 0;
  logic ce_run = 1'b0;
  always @(negedge clk) begin
    if (!ce_run) pix_ce = 1'b0;
    else begin
      pix_ce = (ce_cnt == 0);
      ce_cnt = (ce_cnt + 1 >= ce_div) ? 0 : ce_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_tick(input logic fv, input logic lv, input logic [11:0] d,
                           input logic fd, input logic [15:0] fc);
    tick_t t;
    t.fv = fv; t.lv = lv; t.data = d; t.fd = fd; t.fc = fc;
    exp_q.push_back(t);
  endtask

  // Hand-derived pixel values: ramps follow column/line, checker is all-ones on even x+y.
  function automatic logic [11:0] exp_pix(input int pat, input int x, input int y);
    case (pat)
      0:       return 12'(x);
      1:       return 12'(y);
      default: return (((x + y) % 2) == 0) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  task automatic push_frame(input int pat, input bit from_idle, input logic [15:0] fc);
    if (from_idle) push_tick(1'b0, 1'b0, 12'h0, 1'b0, fc);
    repeat (VBLANK) push_tick(1'b0, 1'b0, 12'h0, 1'b0, fc);
    repeat (FV_LEAD) push_tick(1'b1, 1'b0, 12'h0, 1'b0, fc);
    for (int y = 0; y < HEIGHT; y++) begin
      for (int x = 0; x < WIDTH; x++) push_tick(1'b1, 1'b1, exp_pix(pat, x, y), 1'b0, fc);
      if (y < HEIGHT - 1) repeat (HBLANK) push_tick(1'b1, 1'b0, 12'h0, 1'b0, fc);
    end
    push_tick(1'b1, 1'b0, 12'h0, 1'b1, fc + 16'd1);
  endtask

  task automatic wait_empty(input string name, input int budget);
    int i;
    i = 0;
    while (exp_q.size() > 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected ticks not seen after %0d clks, required 0",
               name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // Monitor: compares every pixel-tick sample with the queue and checks hold between ticks.
  tick_t got, prev, expv;
  bit    have_prev = 0;
  bit    prev_fd   = 0;
  logic  ce_e, rst_e;
  int    fd_wide   = 0;
  int    fd_total  = 0;
  always @(posedge clk) begin
    ce_e  = pix_ce;
    rst_e = reset;
    #1;
    got = {frame_valid, line_valid, data, frame_done, frame_count};
    if (frame_done) fd_total++;
    if (frame_done && prev_fd) fd_wide++;
    prev_fd = frame_done;
    if (rst_e) have_prev = 0;
    else if (ce_e) begin
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        chk("tick{fv,lv,data,fd,fc}", 32'(got), 32'(expv));
      end
      prev = got;
      have_prev = 1;
    end else if (have_prev) begin
      chk("hold{fv,lv,data,fc}", {2'b0, got.fv, got.lv, got.data, got.fc},
          {2'b0, prev.fv, prev.lv, prev.data, prev.fc});
      chk("frame_done_offtick", 32'(frame_done), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, fd_before;

    // Test 1: reset held 5 clocks
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_fv", 32'(frame_valid), 32'd0);
    chk("rst_lv", 32'(line_valid), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset  = 1'b0;
    ce_div = 1;
    ce_run = 1'b1;
    @(negedge clk);

    // Tests 2 and 3: h-ramp frame, then a second frame with enable dropped in line 1
    push_frame(0, 1'b1, 16'd0);
    push_frame(0, 1'b0, 16'd1);
    repeat (5) push_tick(1'b0, 1'b0, 12'h0, 1'b0, 16'd2);
    pattern = 2'd0;
    enable  = 1'b1;
    @(posedge clk); #1;
    chk("busy_rise", 32'(busy), 32'd1);
    k = 0;
    while (!frame_valid && k < 50) begin @(posedge clk); #1; k++; end
    chk("vblank_ticks_before_fv", 32'(k - 1), 32'd3);
    while (!frame_done && k < 100) begin @(posedge clk); #1; k++; end
    chk("frame_done_tick", 32'(k), 32'd21);
    repeat (12) @(negedge clk);
    chk("mid_line1_lv", 32'(line_valid), 32'd1);
    enable = 1'b0;
    wait_empty("frames_t2_t3", 200);
    chk("t3_busy_fell", 32'(busy), 32'd0);
    chk("t3_frame_count", 32'(frame_count), 32'd2);
    chk("t3_no_fv", 32'(frame_valid), 32'd0);

    // Test 4: pixel tick every third clock
    ce_div = 3;
    @(negedge clk);
    fd_before = fd_total;
    push_frame(0, 1'b1, 16'd2);
    repeat (3) push_tick(1'b0, 1'b0, 12'h0, 1'b0, 16'd3);
    enable = 1'b1;
    k = 0;
    while (!busy && k < 20) begin @(negedge clk); k++; end
    chk("t4_busy_rise", 32'(busy), 32'd1);
    enable = 1'b0;
    wait_empty("frame_t4", 400);
    chk("t4_frame_done_pulses", 32'(fd_total - fd_before), 32'd1);
    chk("t4_frame_done_width", 32'(fd_wide), 32'd0);
    chk("t4_frame_count", 32'(frame_count), 32'd3);

    // Test 5: reset during LINE
    ce_div = 1;
    @(negedge clk);
    enable = 1'b1;
    k = 0;
    while (!line_valid && k < 50) begin @(negedge clk); k++; end
    chk("t5_in_line", 32'(line_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t5_fv", 32'(frame_valid), 32'd0);
    chk("t5_lv", 32'(line_valid), 32'd0);
    chk("t5_data", 32'(data), 32'd0);
    chk("t5_frame_count", 32'(frame_count), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b0;
    repeat (3) @(negedge clk);

    // Test 6: checker frame; pattern switched to v-ramp mid-frame takes effect next frame
    push_frame(2, 1'b1, 16'd0);
    push_frame(1, 1'b0, 16'd1);
    repeat (3) push_tick(1'b0, 1'b0, 12'h0, 1'b0, 16'd2);
    pattern = 2'd2;
    enable  = 1'b1;
    repeat (8) @(negedge clk);
    pattern = 2'd1;
    k = 0;
    while (frame_count != 16'd1 && k < 100) begin @(negedge clk); k++; end
    chk("t6_first_frame_done", 32'(frame_count), 32'd1);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    wait_empty("frames_t6", 200);
    chk("t6_busy_fell", 32'(busy), 32'd0);
    chk("t6_frame_count", 32'(frame_count), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
